dmux16_8_sched: RTL and testbench

Sequencing controller for the 16-bit 1-to-8 demultiplexer datapath. Accepts 16-bit words on a valid/ready input port and steers each word to one of 8 destinations by driving the demux select and data inputs. Raises a one-hot per-destination valid until that destination accepts the word. Supports addressed mode and round-robin mode, and drops words whose destination stalls past a timeout.

---
 rtl/dmux16_8_sched.sv | 107 ++++++++++
 tb/tb_dmux16_8_sched.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dmux16_8_sched.sv
`default_nettype none
// ============================================================================
//  Module   : dmux16_8_sched
//  Purpose  : Sequencing controller for a 16-bit 1-to-8 demultiplexer.
//             Accepts words on a valid/ready port, steers each word to one
//             of 8 destinations (addressed or round-robin), holds a one-hot
//             valid until the destination accepts, and drops words whose
//             destination stalls past TIMEOUT cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module dmux16_8_sched #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_dest,
  input  logic             rr_mode,
  input  logic [7:0]       out_ready,
  output logic [2:0]       dmux_sel,
  output logic [WIDTH-1:0] dmux_a,
  output logic [7:0]       out_valid,
  output logic             busy,
  output logic             drop_pulse,
  output logic [CNT_W-1:0] drop_count
);

  // Wait counter only needs to reach TIMEOUT-1; it saturates when the
  // timeout is disabled so it can never wrap into a false match.
  localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit TO_EN = (TIMEOUT != 0);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]      state;
  logic [2:0]      rr_ptr;
  logic [WC_W-1:0] wait_cnt;

  logic       sel_ready;
  logic       accept;
  logic       handshake;
  logic       timeout_hit;
  logic [2:0] next_dest;

  // Selected destination's ready closes the loop back to the upstream port,
  // which is what allows one word per cycle while in SEND.
  assign sel_ready   = out_ready[dmux_sel];
  assign in_ready    = (state == ST_IDLE) | sel_ready;
  assign accept      = in_valid & in_ready;
  assign handshake   = (state == ST_SEND) & sel_ready;
  assign timeout_hit = TO_EN & (state == ST_SEND) & ~sel_ready & (wait_cnt == WC_LAST);
  assign next_dest   = rr_mode ? rr_ptr : in_dest;
  assign busy        = (state == ST_SEND);

  // Main sequencer: word load, handshake/timeout resolution and drop stats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rr_ptr     <= 3'd0;
      dmux_sel   <= 3'd0;
      dmux_a     <= '0;
      out_valid  <= 8'd0;
      drop_pulse <= 1'b0;
      drop_count <= '0;
      wait_cnt   <= '0;
    end else begin
      drop_pulse <= 1'b0;
      if (accept) begin
        // New word: valid in IDLE, or in SEND when the held word hands off.
        state     <= ST_SEND;
        dmux_sel  <= next_dest;
        dmux_a    <= in_data;
        out_valid <= 8'b1 << next_dest;
        wait_cnt  <= '0;
        if (rr_mode) begin
          rr_ptr <= rr_ptr + 3'd1;
        end
      end else if (handshake) begin
        state     <= ST_IDLE;
        dmux_a    <= '0;
        out_valid <= 8'd0;
        wait_cnt  <= '0;
      end else if (timeout_hit) begin
        state      <= ST_IDLE;
        dmux_a     <= '0;
        out_valid  <= 8'd0;
        wait_cnt   <= '0;
        drop_pulse <= 1'b1;
        if (drop_count != {CNT_W{1'b1}}) begin
          drop_count <= drop_count + 1'b1;
        end
      end else if (state == ST_SEND) begin
        if (wait_cnt != {WC_W{1'b1}}) begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmux16_8_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmux16_8_sched
//  Purpose  : Self-checking bench for dmux16_8_sched against a word-level
//             reference model (held word, its age, pointer, drop tally).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmux16_8_sched;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [2:0]  in_dest = '0;
  logic        rr_mode = 1'b0;
  logic [7:0]  out_ready = '0;
  logic [2:0]  dmux_sel;
  logic [15:0] dmux_a;
  logic [7:0]  out_valid;
  logic        busy;
  logic        drop_pulse;
  logic [7:0]  drop_count;

  dmux16_8_sched #(.WIDTH(16), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dest(in_dest), .rr_mode(rr_mode),
    .out_ready(out_ready), .dmux_sel(dmux_sel), .dmux_a(dmux_a),
    .out_valid(out_valid), .busy(busy), .drop_pulse(drop_pulse),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the word currently owed to a destination.
  bit          m_held;
  int          m_dest;
  logic [15:0] m_data;
  int          m_age;
  int          m_rr;
  int          m_drops;
  bit          m_pulse;
  int          m_sel;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held = 0; m_dest = 0; m_data = '0; m_age = 0;
    m_rr = 0; m_drops = 0; m_pulse = 0; m_sel = 0;
  endtask

  // One clock: drive at negedge, check in_ready, advance model, check outputs.
  task automatic step(input bit rst, input bit v, input logic [15:0] d,
                      input logic [2:0] dst, input bit rr, input logic [7:0] ordy);
    bit hs, ir, acc;
    @(negedge clk);
    rst_n = ~rst; in_valid = v; in_data = d; in_dest = dst; rr_mode = rr; out_ready = ordy;
    #1;
    ir = !m_held || ordy[m_dest];
    if (!rst) chk("in_ready", 32'(in_ready), 32'(ir));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      hs  = m_held && ordy[m_dest];
      acc = v && ir;
      m_pulse = 0;
      if (m_held && !hs) begin
        m_age++;
        if (TO != 0 && m_age == TO) begin
          m_held = 0;
          m_pulse = 1;
          if (m_drops < 255) m_drops++;
        end
      end
      if (hs) m_held = 0;
      if (acc) begin
        m_dest = rr ? m_rr : int'(dst);
        if (rr) m_rr = (m_rr + 1) % 8;
        m_held = 1; m_age = 0; m_data = d; m_sel = m_dest;
      end
    end
    #1;
    chk("out_valid",  32'(out_valid),  m_held ? (32'd1 << m_dest) : 32'd0);
    chk("dmux_a",     32'(dmux_a),     m_held ? 32'(m_data) : 32'd0);
    chk("dmux_sel",   32'(dmux_sel),   32'(m_sel));
    chk("busy",       32'(busy),       32'(m_held));
    chk("drop_pulse", 32'(drop_pulse), 32'(m_pulse));
    chk("drop_count", 32'(drop_count), 32'(m_drops));
  endtask

  task automatic idle_step(input logic [7:0] ordy);
    step(0, 0, 16'h0, 3'd0, 0, ordy);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_before;
    model_reset();

    // Reset and post-reset state.
    step(1, 0, 16'h0, 3'd0, 0, 8'h00);
    step(1, 0, 16'h0, 3'd0, 0, 8'h00);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    idle_step(8'h00);

    // Addressed send to destination 5.
    step(0, 1, 16'hFFFF, 3'd5, 0, 8'hFF);
    chk("addr_sel", 32'(dmux_sel), 32'd5);
    chk("addr_ov",  32'(out_valid), 32'h20);
    idle_step(8'hFF);
    chk("addr_done", 32'(out_valid), 32'd0);

    // Round-robin sweep of 9 words, one per cycle, wrapping to 0.
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 16'(i + 1), 3'd6, 1, 8'hFF);
      chk("rr_sel", 32'(dmux_sel), 32'(i % 8));
    end
    idle_step(8'hFF);

    // Backpressure on destination 3 for 4 cycles.
    step(0, 1, 16'hBEEF, 3'd3, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 16'h1234, 3'd1, 0, 8'hF7);
      chk("bp_hold", 32'(dmux_a), 32'hBEEF);
    end
    idle_step(8'h08);
    chk("bp_nodrop", 32'(drop_count), 32'd1 - 32'd1);

    // Timeout: destination 7 never ready.
    step(0, 1, 16'hA5A5, 3'd7, 0, 8'h00);
    for (int i = 0; i < TO; i++) idle_step(8'h00);
    chk("to_count", 32'(drop_count), 32'd1);
    chk("to_pulse", 32'(drop_pulse), 32'd1);
    idle_step(8'h00);

    // Timeout boundary: ready arrives exactly on the last allowed cycle.
    cnt_before = m_drops;
    step(0, 1, 16'h5A5A, 3'd7, 0, 8'h00);
    for (int i = 0; i < TO - 1; i++) idle_step(8'h7F);
    idle_step(8'h80);
    idle_step(8'h00);
    chk("bnd_pulse", 32'(drop_pulse), 32'd0);
    chk("bnd_count", 32'(drop_count), 32'(cnt_before));

    // Randomized traffic with occasional long stalls.
    for (int i = 0; i < 2500; i++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      step(0, bit'($urandom_range(0, 1)), 16'($urandom), 3'($urandom), bit'($urandom_range(0, 1)), r);
    end

    // Reset while a word is held; pointer returns to 0.
    step(0, 1, 16'hCAFE, 3'd2, 1, 8'h00);
    idle_step(8'h00);
    step(1, 0, 16'h0, 3'd0, 0, 8'h00);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cnt",  32'(drop_count), 32'd0);
    step(0, 1, 16'h0101, 3'd4, 1, 8'hFF);
    chk("mid_rst_rr", 32'(dmux_sel), 32'd0);
    idle_step(8'hFF);

    // Saturation: 300 drops.
    for (int k = 0; k < 300; k++) begin
      step(0, 1, 16'($urandom), 3'($urandom), 0, 8'h00);
      for (int i = 0; i < TO; i++) idle_step(8'h00);
    end
    chk("sat_count", 32'(drop_count), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
